muldiv_sequencer: RTL and testbench

Multi-cycle HI/LO unit for the EX stage of the CPU core. It takes an EX-stage operation whose FUNCT code is one of MULT, MULTU, DIV, DIVU, MTHI or MTLO. It sequences a shared radix-2 iterative multiply/divide datapath over 32 iterations and stalls the pipeline while the operation runs. It owns the architectural HI and LO registers.

---
 rtl/muldiv_sequencer_pkg.sv | 30 +++
 rtl/muldiv_iter.sv | 42 ++++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM encodings, iteration
// count, the FUNCT codes it decodes, and small arithmetic helpers.
package muldiv_sequencer_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // 0x18..0x1B share the upper four bits; bit 1 selects divide, bit 0 unsigned.
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f[5:2] == 4'b0110);
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step of the shared datapath: shift-add multiply or restoring
// shift-subtract divide on the {acc, q} register pair.
module muldiv_iter (
    input  logic        is_div,
    input  logic [32:0] acc,
    input  logic [31:0] q,
    input  logic [31:0] opnd,
    output logic [32:0] acc_next,
    output logic [31:0] q_next
);

    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [33:0] diff_s;

    // Single iteration; multiply shifts right, divide shifts left.
    always_comb begin
        sum_s     = acc;
        shifted_s = {acc[31:0], q[31]};
        diff_s    = {1'b0, shifted_s} - {2'b00, opnd};
        acc_next  = acc;
        q_next    = q;
        if (is_div) begin
            if (!diff_s[33]) begin
                acc_next = diff_s[32:0];
                q_next   = {q[30:0], 1'b1};
            end else begin
                acc_next = shifted_s;
                q_next   = {q[30:0], 1'b0};
            end
        end else begin
            if (q[0]) begin
                sum_s = acc + {1'b0, opnd};
            end else begin
                sum_s = acc;
            end
            acc_next = {1'b0, sum_s[32:1]};
            q_next   = {sum_s[0], q[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage HI/LO unit: sequences 32 iterations of muldiv_iter, applies sign fixup,
// owns HI/LO and stalls the pipeline while a MULT/DIV is in flight.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_r, state_s;
    logic [4:0]  count_r;
    logic [32:0] acc_r, acc_s;
    logic [31:0] q_r, q_s, opnd_r;
    logic        is_div_r, neg_res_r, neg_rem_r;
    logic [31:0] hi_r, lo_r, hi_fix_s, lo_fix_s;
    logic        accept_s, mthi_s, mtlo_s, stall_s, done_s;
    logic        sign_a_s, sign_b_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [63:0] prod_s;

    muldiv_iter u_iter (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .q        (q_r),
        .opnd     (opnd_r),
        .acc_next (acc_s),
        .q_next   (q_s)
    );

    // Decode of the instruction offered in IDLE; flush blocks acceptance.
    always_comb begin
        accept_s = (state_r == MD_IDLE) && start && !flush && is_muldiv(funct);
        mthi_s   = (state_r == MD_IDLE) && start && !flush && (funct == FUNCT_MTHI);
        mtlo_s   = (state_r == MD_IDLE) && start && !flush && (funct == FUNCT_MTLO);
        sign_a_s = !funct[0] && op_a[31];
        sign_b_s = !funct[0] && op_b[31];
        mag_a_s  = sign_a_s ? abs32(op_a) : op_a;
        mag_b_s  = sign_b_s ? abs32(op_b) : op_b;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            MD_IDLE: state_s = accept_s ? MD_RUN : MD_IDLE;
            MD_RUN: begin
                if (flush) begin
                    state_s = MD_IDLE;
                end else if (count_r == 5'(ITER - 1)) begin
                    state_s = MD_FIX;
                end else begin
                    state_s = MD_RUN;
                end
            end
            MD_FIX:  state_s = flush ? MD_IDLE : MD_DONE;
            MD_DONE: state_s = MD_IDLE;
            default: state_s = MD_IDLE;
        endcase
    end

    // Outputs; the IDLE term of stall must see the offered instruction this cycle.
    always_comb begin
        stall_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            MD_IDLE: stall_s = accept_s;
            MD_RUN:  stall_s = 1'b1;
            MD_FIX:  stall_s = 1'b1;
            MD_DONE: done_s  = 1'b1;
            default: stall_s = 1'b0;
        endcase
    end

    // Operand latch on accept, then one datapath step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= 5'd0;
            acc_r     <= 33'd0;
            q_r       <= 32'd0;
            opnd_r    <= 32'd0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (accept_s) begin
            count_r   <= 5'd0;
            acc_r     <= 33'd0;
            is_div_r  <= funct[1];
            q_r       <= funct[1] ? mag_a_s : mag_b_s;
            opnd_r    <= funct[1] ? mag_b_s : mag_a_s;
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
        end else if (state_r == MD_RUN) begin
            count_r <= count_r + 5'd1;
            acc_r   <= acc_s;
            q_r     <= q_s;
        end
    end

    // Sign fixup: quotient follows sign difference, remainder follows the dividend.
    always_comb begin
        prod_s   = {acc_r[31:0], q_r};
        hi_fix_s = 32'd0;
        lo_fix_s = 32'd0;
        if (is_div_r) begin
            lo_fix_s = neg_res_r ? (32'd0 - q_r) : q_r;
            hi_fix_s = neg_rem_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        end else begin
            {hi_fix_s, lo_fix_s} = neg_res_r ? (64'd0 - prod_s) : prod_s;
        end
    end

    // Architectural HI/LO: written only at the FIX edge or by MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if ((state_r == MD_FIX) && !flush) begin
            hi_r <= hi_fix_s;
            lo_r <= lo_fix_s;
        end else begin
            if (mthi_s) begin
                hi_r <= op_a;
            end
            if (mtlo_s) begin
                lo_r <= op_a;
            end
        end
    end

    assign stall = stall_s;
    assign done  = done_s;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer with hand-computed expected results.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk, rst_n, start, flush;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        stall, done;
    logic [31:0] hi, lo;

    int vec_cnt = 0;
    int err_cnt = 0;

    muldiv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a rising edge; cycle 0 is the offer cycle. Collects stall and done
    // statistics over ncyc cycles and returns just after the edge that starts cycle ncyc.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int flush_cyc, input int ncyc,
                          output int stalls, output int dcyc, output int dcnt);
        start  = 1'b1;
        funct  = f;
        op_a   = a;
        op_b   = b;
        flush  = (flush_cyc == 0);
        stalls = 0;
        dcyc   = -1;
        dcnt   = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (stall === 1'b1) stalls++;
            if (done === 1'b1) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            flush = ((c + 1) == flush_cyc);
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        funct = 6'h00;
        op_a  = 32'd0;
        op_b  = 32'd0;
        #12;
        vec_cnt++;
        if ({hi, lo} !== 64'd0) begin
            err_cnt++;
            $display("FAIL reset_hilo: got %h required 0", {hi, lo});
        end
        vec_cnt++;
        if ({stall, done} !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_ctrl: stall/done got %b required 00", {stall, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult;
        int s, dc, dn;
        run_op(FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, -1, 40, s, dc, dn);
        vec_cnt++;
        if (s !== 34) begin
            err_cnt++;
            $display("FAIL mult_stall_cycles: got %0d required 34", s);
        end
        vec_cnt++;
        if (dc !== 34 || dn !== 1) begin
            err_cnt++;
            $display("FAIL mult_done: cycle %0d count %0d required cycle 34 count 1", dc, dn);
        end
        vec_cnt++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
            err_cnt++;
            $display("FAIL mult_result: got %h required FFFFFFFFFFFFFFF1", {hi, lo});
        end
    endtask

    task automatic test_div;
        int s, dc, dn;
        run_op(FUNCT_DIVU, 32'd100, 32'd7, 1'b0, -1, 40, s, dc, dn);
        vec_cnt++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            err_cnt++;
            $display("FAIL divu_result: got hi %h lo %h required hi 2 lo e", hi, lo);
        end
        run_op(FUNCT_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, -1, 40, s, dc, dn);
        vec_cnt++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            err_cnt++;
            $display("FAIL div_signed: got hi %h lo %h required hi ffffffff lo fffffffd", hi, lo);
        end
    endtask

    task automatic test_div_edge;
        int s, dc, dn;
        run_op(FUNCT_DIVU, 32'h1234, 32'd0, 1'b0, -1, 40, s, dc, dn);
        vec_cnt++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'h1234 || dn !== 1) begin
            err_cnt++;
            $display("FAIL div_by_zero: got hi %h lo %h done %0d required hi 1234 lo ffffffff done 1",
                     hi, lo, dn);
        end
        run_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, 40, s, dc, dn);
        vec_cnt++;
        if (lo !== 32'h80000000 || hi !== 32'd0) begin
            err_cnt++;
            $display("FAIL div_overflow: got hi %h lo %h required hi 0 lo 80000000", hi, lo);
        end
    endtask

    task automatic test_flush;
        int s, dc, dn;
        logic [31:0] lo_before;
        run_op(FUNCT_MTHI, 32'hAAAA5555, 32'd0, 1'b0, -1, 1, s, dc, dn);
        vec_cnt++;
        if (s !== 0) begin
            err_cnt++;
            $display("FAIL mthi_stall: got %0d stall cycles required 0", s);
        end
        @(negedge clk);
        vec_cnt++;
        if (hi !== 32'hAAAA5555) begin
            err_cnt++;
            $display("FAIL mthi_value: got %h required aaaa5555", hi);
        end
        lo_before = lo;
        @(posedge clk);
        #1;
        run_op(FUNCT_MULT, 32'd2, 32'd3, 1'b0, 10, 20, s, dc, dn);
        vec_cnt++;
        if (s !== 11 || dn !== 0) begin
            err_cnt++;
            $display("FAIL flush_run: stall cycles %0d done %0d required 11 and 0", s, dn);
        end
        vec_cnt++;
        if (hi !== 32'hAAAA5555 || lo !== lo_before) begin
            err_cnt++;
            $display("FAIL flush_hilo: got hi %h lo %h required hi aaaa5555 lo %h",
                     hi, lo, lo_before);
        end
    endtask

    task automatic test_back_to_back;
        int s, dc, dn;
        run_op(FUNCT_MULTU, 32'd6, 32'd7, 1'b1, -1, 35, s, dc, dn);
        vec_cnt++;
        if (s !== 34 || dn !== 1 || dc !== 34) begin
            err_cnt++;
            $display("FAIL hold_start: stalls %0d done %0d at %0d required 34, 1 at 34", s, dn, dc);
        end
        vec_cnt++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            err_cnt++;
            $display("FAIL hold_result: got hi %h lo %h required hi 0 lo 2a", hi, lo);
        end
        funct = FUNCT_MTLO;
        op_a  = 32'h00005A5A;
        @(negedge clk);
        vec_cnt++;
        if (stall !== 1'b0) begin
            err_cnt++;
            $display("FAIL mtlo_stall: got %b required 0", stall);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (lo !== 32'h00005A5A || hi !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
            err_cnt++;
            $display("FAIL mtlo_after_done: hi %h lo %h done %b stall %b required 0 5a5a 0 0",
                     hi, lo, done, stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun;
        int s, dc, dn;
        run_op(FUNCT_MULT, 32'd9, 32'd9, 1'b0, -1, 15, s, dc, dn);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({hi, lo} !== 64'd0 || stall !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_midrun: hi %h lo %h stall %b done %b required all 0",
                     hi, lo, stall, done);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 40, s, dc, dn);
        vec_cnt++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || dn !== 1) begin
            err_cnt++;
            $display("FAIL multu_max: got hi %h lo %h done %0d required fffffffe 00000001 1",
                     hi, lo, dn);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_flush();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
